pipe_ctrl: RTL and testbench

Central pipeline sequencer for the five-stage OpenMIPS core. It merges stall requests from ID (load-use hazard) and EX (multi-cycle ALU ops such as madd/div) into one per-stage stall vector. It owns the multi-cycle EX occupancy counter and the exception flush window, and counts stall cycles for performance debug. It sits beside the pipeline registers: pc_reg, if_id, id_ex, ex_mem and mem_wb all consume its stall/flush outputs.

---
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the five-stage core.
// Merges ID load-use and EX multi-cycle stall requests into one per-stage
// stall vector, owns the EX occupancy counter and the exception flush window,
// and keeps a saturating count of PC-stall cycles for performance debug.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no multi-cycle op, no flush window; load-use stalls only
//   MC_BUSY | EX occupied by a multi-cycle op; mc_cnt = remaining stall cycles
//   FLUSH   | flush window after an exception; fl_cnt = remaining cycles
module pipe_ctrl #(
  parameter int MC_W         = 6,
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              ex_mc_start,
  input  logic [MC_W-1:0]   ex_mc_cycles,
  input  logic              flush_req,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MC_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // PC, IF/ID, ID/EX held for a load-use bubble; EX/MEM also held while EX is occupied
  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;
  localparam logic [3:0]  FL_INIT    = 4'(FLUSH_CYCLES - 1);
  localparam logic [MC_W-1:0] MC_ONE = MC_W'(1);
  localparam logic [MC_W-1:0] MC_TWO = MC_W'(2);

  state_t           state;
  logic [MC_W-1:0]  mc_cnt;
  logic [3:0]       fl_cnt;
  logic             mc_start_ok;

  // A start with length 0 or 1 finishes in its own EX cycle and needs no sequencing
  assign mc_start_ok = ex_mc_start && (ex_mc_cycles > MC_ONE);

  // Same-cycle stall/flush/done decode; reset forces everything quiet
  always_comb begin
    stall   = STALL_NONE;
    flush   = 1'b0;
    mc_done = 1'b0;
    if (!rst) begin
      if (flush_req) begin
        flush = 1'b1;
      end else begin
        case (state)
          FLUSH: begin
            flush = 1'b1;
          end
          MC_BUSY: begin
            if (mc_cnt != '0) begin
              stall = STALL_EX;
            end else begin
              mc_done = 1'b1;
              stall   = stallreq_id ? STALL_ID : STALL_NONE;
            end
          end
          default: begin
            if (mc_start_ok) begin
              stall = STALL_EX;
            end else if (stallreq_id) begin
              stall = STALL_ID;
            end
          end
        endcase
      end
    end
  end

  assign mc_busy = (state == MC_BUSY) && !rst;

  // Sequencer state, occupancy and flush-window counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mc_cnt <= '0;
      fl_cnt <= '0;
    end else if (flush_req) begin
      // exception wins: abandon any multi-cycle op and (re)open the window
      mc_cnt <= '0;
      if (FLUSH_CYCLES <= 1) begin
        state  <= IDLE;
        fl_cnt <= '0;
      end else begin
        state  <= FLUSH;
        fl_cnt <= FL_INIT;
      end
    end else begin
      case (state)
        FLUSH: begin
          if (fl_cnt <= 4'd1) begin
            state  <= IDLE;
            fl_cnt <= '0;
          end else begin
            fl_cnt <= fl_cnt - 4'd1;
          end
        end
        MC_BUSY: begin
          if (mc_cnt != '0) begin
            mc_cnt <= mc_cnt - MC_ONE;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          if (mc_start_ok) begin
            // start cycle and done cycle are not counted in mc_cnt
            mc_cnt <= ex_mc_cycles - MC_TWO;
            state  <= MC_BUSY;
          end
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall[0] && (stall_cycles != {PERF_W{1'b1}})) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, load-use, multi-cycle, flush abort,
// simultaneous requests, reset abort and counter saturation.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stallreq_id;
  logic       ex_mc_start;
  logic [5:0] ex_mc_cycles;
  logic       flush_req;

  logic [5:0] stall;
  logic       flush, mc_busy, mc_done;
  logic [3:0] stall_cycles;

  logic [5:0]  stall1;
  logic        flush1, mc_busy1, mc_done1;
  logic [31:0] stall_cycles1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_W(6), .FLUSH_CYCLES(3), .PERF_W(4)) u_dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles), .flush_req(flush_req), .stall(stall),
    .flush(flush), .mc_busy(mc_busy), .mc_done(mc_done), .stall_cycles(stall_cycles)
  );

  // single-cycle flush window instance sharing the same stimulus
  pipe_ctrl #(.MC_W(6), .FLUSH_CYCLES(1), .PERF_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles), .flush_req(flush_req), .stall(stall1),
    .flush(flush1), .mc_busy(mc_busy1), .mc_done(mc_done1), .stall_cycles(stall_cycles1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // apply inputs just after a falling edge, then let combinational outputs settle
  task automatic drive(input logic r, input logic sid, input logic st,
                       input logic [5:0] n, input logic fr);
    @(negedge clk);
    rst = r; stallreq_id = sid; ex_mc_start = st; ex_mc_cycles = n; flush_req = fr;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [5:0] e_stall, input logic e_flush,
                         input logic e_busy, input logic e_done);
    chk({tag, "_stall"}, 32'(stall), 32'(e_stall));
    chk({tag, "_flush"}, 32'(flush), 32'(e_flush));
    chk({tag, "_busy"},  32'(mc_busy), 32'(e_busy));
    chk({tag, "_done"},  32'(mc_done), 32'(e_done));
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b1; ex_mc_start = 1'b1; ex_mc_cycles = 6'd5; flush_req = 1'b1;

    // reset held 3 cycles with every request high
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 6'd5, 1'b1);
      chk_out("rst", 6'h00, 1'b0, 1'b0, 1'b0);
      if (i > 0) chk("rst_cnt", 32'(stall_cycles), 32'd0);
    end

    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    chk_out("idle", 6'h00, 1'b0, 1'b0, 1'b0);
    chk("idle_cnt", 32'(stall_cycles), 32'd0);

    // load-use for two cycles
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    chk_out("lu1", 6'h07, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    chk_out("lu2", 6'h07, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    chk_out("lu_end", 6'h00, 1'b0, 1'b0, 1'b0);
    chk("lu_cnt", 32'(stall_cycles), 32'd2);

    // multi-cycle N=4 with start held
    drive(1'b0, 1'b0, 1'b1, 6'd4, 1'b0);
    chk_out("mc4_c1", 6'h0F, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 6'd4, 1'b0);
    chk_out("mc4_c2", 6'h0F, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 6'd4, 1'b0);
    chk_out("mc4_c3", 6'h0F, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 6'd4, 1'b0);
    chk_out("mc4_c4", 6'h00, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 6'd1, 1'b0);
    chk_out("mc1", 6'h00, 1'b0, 1'b0, 1'b0);
    chk("mc_cnt", 32'(stall_cycles), 32'd5);
    drive(1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
    chk_out("mc0", 6'h00, 1'b0, 1'b0, 1'b0);

    // N=8, flush in third busy cycle, load-use and starts ignored during window
    drive(1'b0, 1'b0, 1'b1, 6'd8, 1'b0);
    chk_out("fa_start", 6'h0F, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    chk_out("fa_b1", 6'h0F, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    chk_out("fa_b2", 6'h0F, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b1);
    chk_out("fa_fl1", 6'h00, 1'b1, 1'b1, 1'b0);
    chk("fa_fl1_d1", 32'(flush1), 32'd1);
    drive(1'b0, 1'b1, 1'b1, 6'd3, 1'b0);
    chk_out("fa_fl2", 6'h00, 1'b1, 1'b0, 1'b0);
    chk("fa_d1_flush", 32'(flush1), 32'd0);
    chk("fa_d1_stall", 32'(stall1), 32'h0F);
    drive(1'b0, 1'b1, 1'b1, 6'd3, 1'b0);
    chk_out("fa_fl3", 6'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    chk_out("fa_after", 6'h00, 1'b0, 1'b0, 1'b0);
    chk("fa_cnt", 32'(stall_cycles), 32'd8);

    // flush_req inside the window restarts it
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    chk_out("fr_1", 6'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    chk_out("fr_2", 6'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    chk_out("fr_re1", 6'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    chk_out("fr_re2", 6'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    chk_out("fr_re3", 6'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    chk_out("fr_end", 6'h00, 1'b0, 1'b0, 1'b0);

    // simultaneous load-use and N=2 start
    drive(1'b0, 1'b1, 1'b1, 6'd2, 1'b0);
    chk_out("sim1", 6'h0F, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    chk_out("sim2", 6'h07, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    chk_out("sim3", 6'h00, 1'b0, 1'b0, 1'b0);
    chk("sim_cnt", 32'(stall_cycles), 32'd10);

    // reset in the middle of a multi-cycle op gives no mc_done
    drive(1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    chk_out("ra_start", 6'h0F, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    chk_out("ra_rst", 6'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    chk_out("ra_after", 6'h00, 1'b0, 1'b0, 1'b0);
    chk("ra_cnt", 32'(stall_cycles), 32'd0);

    // saturation of the 4-bit counter with load-use held 20 cycles
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
      chk("sat_stall", 32'(stall), 32'h07);
      chk("sat_cnt", 32'(stall_cycles), (i < 15) ? 32'(i) : 32'd15);
    end
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    chk("sat_final", 32'(stall_cycles), 32'd15);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    chk("sat_hold", 32'(stall_cycles), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
